bus_rr_burst_arbiter: RTL and testbench
=======================================

Name: bus_rr_burst_arbiter

Overview:
- Sequencing controller for the shared packet bus between `drvrs` per-driver FIFOs.
- Arbitrates pending FIFOs round-robin, with up to `max_burst` packets per grant.
- Pops the winner's head packet, decodes its destination ID, and pushes it to the target FIFO(s).
- Stalls on destination backpressure. Drops and counts packets with an invalid destination.

Parameters:
- drvrs, 12, number of drivers/FIFOs on the bus.
- pckg_sz, 16, packet width in bits; destination ID is bits [pckg_sz-1 -: 8].
- broadcast, 8'hFF, destination ID meaning "all drivers except the source".
- max_burst, 4, maximum consecutive packets served per grant (≥1).

Ports:
- clk  in  1  bus clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  in  drvrs  per-FIFO non-empty flag.
- D_pop  in  drvrs*pckg_sz  per-FIFO head data; slice i is [i*pckg_sz +: pckg_sz].
- full  in  drvrs  per-FIFO full flag (destination backpressure).
- pop  out  drvrs  one-hot, one-cycle pop strobe to the source FIFO.
- push  out  drvrs  one-cycle push strobe mask to destination FIFO(s).
- D_push  out  pckg_sz  packet being delivered.
- gnt  out  drvrs  one-hot current grant; zero when idle.
- busy  out  1  high whenever state != IDLE.
- drop_cnt  out  16  count of dropped packets; saturates at 16'hFFFF.

Behaviour:
- All outputs are registered. On reset low, immediately (asynchronously) force:
  - all outputs = 0;
  - state = IDLE, rr pointer = 0, burst count = 0.
- Reset asserted mid-transfer aborts it; the packet already popped is lost and is not counted.
- Arbitration: pick the first i with pndng[i]=1, searching from ptr upward and wrapping drvrs-1 → 0.
- FSM states and transitions:
  - IDLE: if any pndng, register gnt = onehot(w), burst = 0, go to LATCH.
  - LATCH: if pndng[w]=0, clear gnt and go to IDLE (no pop, no count). Otherwise:
    - D_push <= D_pop slice w;
    - pop[w] <= 1 for exactly one cycle;
    - go to ROUTE.
  - ROUTE: decode dest = D_push[pckg_sz-1 -: 8].
    - dest < drvrs: target = onehot(dest); self-delivery is permitted.
    - dest == broadcast: target = all ones with the source bit cleared.
    - Otherwise: drop_cnt++ (saturating), go to NEXT.
    - For valid targets, go to WAIT_PUSH.
  - WAIT_PUSH: if (target & full) == 0, push <= target for one cycle and go to NEXT. Otherwise hold push = 0 and stay, with no timeout.
    - A broadcast is all-or-nothing: no partial push.
  - NEXT: burst++.
    - If pndng[w]=1 and burst < max_burst, go to LATCH and keep gnt.
    - Else clear gnt, ptr = (w+1) mod drvrs, go to IDLE.
- Latency: pndng sampled in IDLE at edge E.
  - gnt valid after E+1.
  - pop high during the cycle after E+2.
  - push high during the cycle after E+4, with no backpressure.
- Throughput: 4 cycles per packet within a burst. One extra IDLE cycle between grants.
- pop is never asserted twice for the same packet. push and pop are never both high in the same cycle.
- Simultaneous requests: only the rr order matters. A new pndng rising during a burst waits for the burst to end.
- pndng of the source re-sampled in NEXT reflects the post-pop FIFO state (the pop completed 2 edges earlier).
- D_push holds the last packet while idle.

Test Plan:
- Single transfer: D_pop slice 3 = 16'h05AB, pndng = 12'h008 for one packet.
  - Expected: gnt = 12'h008; pop = 12'h008 for 1 cycle; push = 12'h020 with D_push = 16'h05AB at E+4; drop_cnt = 0; back to IDLE with busy = 0.
- Round-robin fairness: max_burst = 1, pndng = 12'hFFF held continuously.
  - Expected: grant order 0, 1, …, 11, 0; each driver gets exactly one packet per 12 grants.
- Burst cap: driver 2 holds 6 packets, driver 7 holds 1, max_burst = 4.
  - Expected: 4 packets from driver 2, then 1 from driver 7, then the remaining 2 from driver 2.
- Broadcast with backpressure: driver 4 sends 16'hFF11 while full[9] = 1 for 10 cycles.
  - Expected: push stays 0 while full[9] is high; push = 12'hFEF one cycle after full[9] clears; D_push = 16'hFF11.
- Invalid destination: driver 0 sends 16'h2000.
  - Expected: pop[0] pulses once; no push; drop_cnt = 1; the next packet is routed normally.
- Async reset: drive reset low during WAIT_PUSH, between clock edges.
  - Expected: gnt, push, pop, busy, D_push and drop_cnt = 0 immediately, without waiting for a clock edge.
  - After release, the first grant goes to the lowest pending index (ptr = 0).

Source files
------------

// File: rtl/bus_rr_burst_arbiter.sv
// Round-robin burst arbiter for a shared packet bus: pops a source FIFO head,
// decodes its destination ID and pushes it to one driver FIFO or all others.
module bus_rr_burst_arbiter #(
   parameter int         drvrs     = 12,
   parameter int         pckg_sz   = 16,
   parameter logic [7:0] broadcast = 8'hFF,
   parameter int         max_burst = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [drvrs-1:0]         pndng,
   input  logic [drvrs*pckg_sz-1:0] D_pop,
   input  logic [drvrs-1:0]         full,
   output logic [drvrs-1:0]         pop,
   output logic [drvrs-1:0]         push,
   output logic [pckg_sz-1:0]       D_push,
   output logic [drvrs-1:0]         gnt,
   output logic                     busy,
   output logic [15:0]              drop_cnt
);
   localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;
   localparam int BW = $clog2(max_burst + 1);
   localparam logic [drvrs-1:0] ONE = drvrs'(1);

   typedef enum logic [2:0] {IDLE, LATCH, ROUTE, WAIT_PUSH, NEXT} state_t;

   state_t             state_reg, state_next;
   logic [IW-1:0]      ptr_reg, ptr_next;
   logic [IW-1:0]      win_reg, win_next;
   logic [BW-1:0]      burst_reg, burst_next;
   logic [drvrs-1:0]   target_reg, target_next;
   logic [drvrs-1:0]   gnt_reg, gnt_next;
   logic [drvrs-1:0]   pop_reg, pop_next;
   logic [drvrs-1:0]   push_reg, push_next;
   logic [pckg_sz-1:0] d_push_reg, d_push_next;
   logic [15:0]        drop_reg, drop_next;
   logic               busy_reg;

   logic [pckg_sz-1:0] slice [drvrs];
   logic [IW-1:0]      pick_idx;
   logic               pick_found;
   logic [7:0]         dest;
   logic [drvrs-1:0]   win_onehot;

   for (genvar gi = 0; gi < drvrs; gi++) begin : g_slice
      assign slice[gi] = D_pop[gi*pckg_sz +: pckg_sz];
   end

   assign dest       = d_push_reg[pckg_sz-1 -: 8];
   assign win_onehot = ONE << win_reg;

   // First pending FIFO at or after the rr pointer, wrapping at drvrs-1.
   always_comb begin
      int            cand;
      logic [IW-1:0] cand_idx;
      pick_idx   = '0;
      pick_found = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      for (int k = 0; k < drvrs; k++) begin
         cand = int'(ptr_reg) + k;
         if (cand >= drvrs) cand = cand - drvrs;
         cand_idx = IW'(cand);
         if (!pick_found && pndng[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      ptr_next    = ptr_reg;
      win_next    = win_reg;
      burst_next  = burst_reg;
      target_next = target_reg;
      gnt_next    = gnt_reg;
      pop_next    = '0;
      push_next   = '0;
      d_push_next = d_push_reg;
      drop_next   = drop_reg;
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               win_next   = pick_idx;
               gnt_next   = ONE << pick_idx;
               burst_next = '0;
               state_next = LATCH;
            end
         end
         LATCH: begin
            if (!pndng[win_reg]) begin
               gnt_next   = '0;
               state_next = IDLE;
            end else begin
               d_push_next = slice[win_reg];
               pop_next    = win_onehot;
               state_next  = ROUTE;
            end
         end
         ROUTE: begin
            if (int'(dest) < drvrs) begin
               target_next = ONE << dest;
               state_next  = WAIT_PUSH;
            end else if (dest == broadcast) begin
               target_next = ~win_onehot;
               state_next  = WAIT_PUSH;
            end else begin
               if (drop_reg != 16'hFFFF) drop_next = drop_reg + 16'd1;
               state_next = NEXT;
            end
         end
         WAIT_PUSH: begin
            // Broadcast waits until every target has room: never a partial push.
            if ((target_reg & full) == '0) begin
               push_next  = target_reg;
               state_next = NEXT;
            end
         end
         NEXT: begin
            burst_next = burst_reg + 1'b1;
            if (pndng[win_reg] && (int'(burst_next) < max_burst)) begin
               state_next = LATCH;
            end else begin
               gnt_next   = '0;
               ptr_next   = (int'(win_reg) == drvrs - 1) ? '0 : win_reg + 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         ptr_reg    <= '0;
         win_reg    <= '0;
         burst_reg  <= '0;
         target_reg <= '0;
         gnt_reg    <= '0;
         pop_reg    <= '0;
         push_reg   <= '0;
         d_push_reg <= '0;
         drop_reg   <= '0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         ptr_reg    <= ptr_next;
         win_reg    <= win_next;
         burst_reg  <= burst_next;
         target_reg <= target_next;
         gnt_reg    <= gnt_next;
         pop_reg    <= pop_next;
         push_reg   <= push_next;
         d_push_reg <= d_push_next;
         drop_reg   <= drop_next;
         busy_reg   <= (state_next != IDLE);
      end
   end

   assign pop      = pop_reg;
   assign push     = push_reg;
   assign D_push   = d_push_reg;
   assign gnt      = gnt_reg;
   assign busy     = busy_reg;
   assign drop_cnt = drop_reg;
endmodule

// File: tb/tb_bus_rr_burst_arbiter.sv
// Scoreboard bench for bus_rr_burst_arbiter: FIFO models feed the bus, expected
// pops and pushes are queued at stimulus time and matched as the DUT emits them.
`timescale 1ns/1ps
module tb_bus_rr_burst_arbiter;
   localparam int N = 12;
   localparam int W = 16;

   logic           clk;
   logic           reset;
   logic [N-1:0]   pndng;
   logic [N*W-1:0] D_pop;
   logic [N-1:0]   full;
   logic [N-1:0]   pop;
   logic [N-1:0]   push;
   logic [W-1:0]   D_push;
   logic [N-1:0]   gnt;
   logic           busy;
   logic [15:0]    drop_cnt;

   bus_rr_burst_arbiter #(
      .drvrs(N), .pckg_sz(W), .broadcast(8'hFF), .max_burst(4)
   ) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
      .pop(pop), .push(push), .D_push(D_push), .gnt(gnt), .busy(busy),
      .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Source FIFO models
   logic [W-1:0] mem [N][16];
   logic [7:0]   wr_cnt [N];
   logic [7:0]   rd_cnt [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_fifo
      assign pndng[gi]        = (wr_cnt[gi] != rd_cnt[gi]);
      assign D_pop[gi*W +: W] = mem[gi][rd_cnt[gi][3:0]];
   end

   int          exp_pop [$];
   logic [27:0] exp_push [$];
   int          n_checks;
   int          n_fail;
   int          cyc;

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic load(input int drv, input logic [W-1:0] data);
      mem[drv][wr_cnt[drv][3:0]] = data;
      wr_cnt[drv] = wr_cnt[drv] + 8'd1;
   endtask

   task automatic expect_pkt(input int drv, input logic [W-1:0] data);
      logic [7:0]   dest;
      logic [N-1:0] mask;
      logic [N-1:0] one;
      one  = 12'h001;
      dest = data[W-1 -: 8];
      mask = '0;
      if (dest < 8'd12) mask = one << dest;
      else if (dest == 8'hFF) mask = ~(one << drv);
      exp_pop.push_back(drv);
      if (mask != '0) exp_push.push_back({mask, data});
   endtask

   task automatic send(input int drv, input logic [W-1:0] data);
      load(drv, data);
      expect_pkt(drv, data);
   endtask

   task automatic fifo_proc();
      forever begin
         @(posedge clk);
         cyc++;
         for (int i = 0; i < N; i++)
            if (pop[i]) rd_cnt[i] = rd_cnt[i] + 8'd1;
      end
   endtask

   task automatic mon_proc();
      int          e;
      logic [27:0] p;
      forever begin
         @(negedge clk);
         if (reset) begin
            check_value("pop_push_excl", 32'(pop & push), 32'h0);
            if (pop != '0) begin
               if (exp_pop.size() == 0) check_value("pop_unexpected", 32'(pop), 32'h0);
               else begin
                  e = exp_pop.pop_front();
                  $display("pop  drv=%0d pop=%03h cycle=%0d", e, pop, cyc);
                  check_value("pop_onehot", 32'(pop), 32'(12'h001 << e));
               end
            end
            if (push != '0) begin
               if (exp_push.size() == 0) check_value("push_unexpected", 32'(push), 32'h0);
               else begin
                  p = exp_push.pop_front();
                  $display("push mask=%03h data=%04h cycle=%0d", push, D_push, cyc);
                  check_value("push_mask", 32'(push), 32'(p[27:16]));
                  check_value("push_data", 32'(D_push), 32'(p[15:0]));
               end
            end
         end
      end
   endtask

   task automatic drain(input string tag, input int max_cyc);
      int t;
      t = 0;
      while (t < max_cyc && !(exp_pop.size() == 0 && exp_push.size() == 0 && !busy)) begin
         @(negedge clk);
         t++;
      end
      check_value({tag, "_drain"}, 32'(exp_pop.size() + exp_push.size()), 32'h0);
      check_value({tag, "_idle"}, 32'(busy), 32'h0);
      check_value({tag, "_empty"}, 32'(pndng), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g_c, p_c, u_c, c0, n_bp;
      logic [N-1:0] g_v;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      reset    = 1'b0;
      full     = '0;
      for (int i = 0; i < N; i++) begin
         wr_cnt[i] = '0;
         rd_cnt[i] = '0;
         for (int j = 0; j < 16; j++) mem[i][j] = '0;
      end
      fork
         fifo_proc();
         mon_proc();
      join_none

      repeat (3) @(negedge clk);
      check_value("rst_gnt", 32'(gnt), 32'h0);
      check_value("rst_pop", 32'(pop), 32'h0);
      check_value("rst_push", 32'(push), 32'h0);
      check_value("rst_busy", 32'(busy), 32'h0);
      check_value("rst_dpush", 32'(D_push), 32'h0);
      check_value("rst_drop", 32'(drop_cnt), 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // Round robin: every driver pending at once, driver 0 refilled after its turn
      for (int i = 0; i < N; i++) send(i, {8'((i + 5) % N), 8'(8'h10 + i)});
      expect_pkt(0, 16'h03EE);
      for (int t = 0; t < 100 && gnt != 12'h002; t++) @(negedge clk);
      check_value("rr_gnt1_reached", 32'(gnt), 32'h002);
      load(0, 16'h03EE);
      drain("rr", 400);

      // Burst cap: 4 from driver 2, 1 from driver 7, then 2 more from driver 2
      for (int k = 0; k < 6; k++) load(2, 16'h0A00 + 16'(k));
      load(7, 16'h0171);
      for (int k = 0; k < 4; k++) expect_pkt(2, 16'h0A00 + 16'(k));
      expect_pkt(7, 16'h0171);
      for (int k = 4; k < 6; k++) expect_pkt(2, 16'h0A00 + 16'(k));
      drain("burst", 200);
      check_value("burst_drop", 32'(drop_cnt), 32'h0);

      // Single transfer latency
      send(3, 16'h05AB);
      c0 = cyc; g_c = -1; p_c = -1; u_c = -1; g_v = '0;
      for (int t = 0; t < 20 && u_c < 0; t++) begin
         @(negedge clk);
         if (gnt != '0 && g_c < 0) begin g_c = cyc; g_v = gnt; end
         if (pop != '0 && p_c < 0) p_c = cyc;
         if (push != '0 && u_c < 0) u_c = cyc;
      end
      check_value("single_gnt", 32'(g_v), 32'h008);
      check_value("single_gnt_lat", 32'(g_c - c0), 32'd1);
      check_value("single_pop_lat", 32'(p_c - c0), 32'd2);
      check_value("single_push_lat", 32'(u_c - c0), 32'd4);
      drain("single", 50);
      check_value("single_drop", 32'(drop_cnt), 32'h0);

      // Invalid destination dropped, next packet routed
      send(0, 16'h2000);
      send(0, 16'h0A55);
      drain("invalid", 50);
      check_value("invalid_drop", 32'(drop_cnt), 32'd1);

      // Broadcast held off by a full destination
      send(4, 16'hFF11);
      full = 12'h200;
      n_bp = 0;
      repeat (10) begin
         @(negedge clk);
         if (push != '0) n_bp++;
      end
      check_value("bp_no_push", 32'(n_bp), 32'h0);
      full = '0;
      @(negedge clk);
      check_value("bp_push", 32'(push), 32'hFEF);
      check_value("bp_dpush", 32'(D_push), 32'hFF11);
      drain("bcast", 50);

      // Async reset while stalled in WAIT_PUSH
      send(6, 16'h0977);
      full = 12'h200;
      repeat (8) @(negedge clk);
      check_value("stall_busy", 32'(busy), 32'd1);
      load(2, 16'h0102);
      load(8, 16'h0308);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check_value("arst_gnt", 32'(gnt), 32'h0);
      check_value("arst_pop", 32'(pop), 32'h0);
      check_value("arst_push", 32'(push), 32'h0);
      check_value("arst_busy", 32'(busy), 32'h0);
      check_value("arst_dpush", 32'(D_push), 32'h0);
      check_value("arst_drop", 32'(drop_cnt), 32'h0);
      exp_pop.delete();
      exp_push.delete();
      full = '0;
      @(negedge clk);
      reset = 1'b1;
      expect_pkt(2, 16'h0102);
      expect_pkt(8, 16'h0308);
      @(negedge clk);
      check_value("arst_first_gnt", 32'(gnt), 32'h004);
      drain("arst", 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
